// File: rtl/bmd_256_echo_scheduler.sv
// bmd_256_echo_scheduler
// Pops arrival timestamps from the RX timestamp FIFO, holds each one until
// echo_delay ticks of waiting_counter have elapsed since its arrival, then
// offers it to the TX packet builder over ts_valid/tx_ready. Counts completed
// echoes and stops once echo_target (nonzero) is reached.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trigger           test enable (level); rising edge clears count/done
//   waiting_counter   free-running counter shared with the FIFO write side
//   echo_delay        minimum ticks between arrival and echo
//   echo_target       echoes before stopping, 0 = unlimited
//   fifo_empty/dout   FIFO status and read data (valid 1 cycle after rd_en)
//   fifo_rd_en        FIFO pop strobe
//   ts_data/ts_valid  timestamp offered to TX builder
//   tx_ready          TX builder accepts ts_data
//   echo_count        completed handshakes since trigger rose
//   done              target reached
//   max_echo_lat      (BMD_256_ECHO_LAT_STAT_EN only) worst arrival->echo latency
//
// Optional feature macro: BMD_256_ECHO_LAT_STAT_EN
module bmd_256_echo_scheduler #(
  parameter int unsigned TS_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [TS_W-1:0]  waiting_counter,
  input  logic [31:0]      echo_delay,
  input  logic [CNT_W-1:0] echo_target,
  input  logic             fifo_empty,
  input  logic [TS_W-1:0]  fifo_dout,
  output logic             fifo_rd_en,
  output logic [TS_W-1:0]  ts_data,
  output logic             ts_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] echo_count,
  output logic             done
`ifdef BMD_256_ECHO_LAT_STAT_EN
  ,
  output logic [TS_W-1:0]  max_echo_lat
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             rd_en_q, rd_en_d;
  logic             ts_valid_q, ts_valid_d;
  logic [TS_W-1:0]  ts_data_q, ts_data_d;
  logic [TS_W-1:0]  ts_reg_q, ts_reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             trig_q;

  logic             rise_c;
  logic             handshake_c;
  logic [TS_W-1:0]  elapsed_c;
  logic             due_c;

  // Trigger rising edge only restarts a test from a quiescent state
  assign rise_c      = trigger && !trig_q && (state_q == IDLE || state_q == DONE);
  assign handshake_c = (state_q == SEND) && tx_ready;
  // Modular subtraction keeps the comparison correct across counter wrap
  assign elapsed_c   = waiting_counter - ts_reg_q;
  assign due_c       = (elapsed_c >= TS_W'(echo_delay));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      ts_valid_q <= 1'b0;
      ts_data_q  <= '0;
      ts_reg_q   <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      ts_valid_q <= ts_valid_d;
      ts_data_q  <= ts_data_d;
      ts_reg_q   <= ts_reg_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      trig_q     <= trigger;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ts_reg_d  = ts_reg_q;
    ts_data_d = ts_data_q;
    cnt_d     = cnt_q;
    done_d    = done_q;

    if (rise_c) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (trigger && !fifo_empty) state_d = FETCH;
      end
      // The read is already issued, so the capture always completes
      FETCH: state_d = LOAD;
      LOAD: begin
        ts_reg_d = fifo_dout;
        state_d  = trigger ? HOLD : IDLE;
      end
      HOLD: begin
        if (!trigger) begin
          state_d = IDLE;
        end else if (due_c) begin
          state_d   = SEND;
          ts_data_d = ts_reg_q;
        end
      end
      // Handshake always completes, even after trigger falls
      SEND: begin
        if (tx_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (echo_target != '0 && cnt_d == echo_target) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (trigger && !fifo_empty) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_en_d    = (state_d == FETCH);
    ts_valid_d = (state_d == SEND);
  end

  assign fifo_rd_en = rd_en_q;
  assign ts_valid   = ts_valid_q;
  assign ts_data    = ts_data_q;
  assign echo_count = cnt_q;
  assign done       = done_q;

`ifdef BMD_256_ECHO_LAT_STAT_EN
  logic [TS_W-1:0] max_lat_q, max_lat_d;
  logic [TS_W-1:0] lat_c;

  assign lat_c = waiting_counter - ts_data_q;

  // Worst-case arrival->echo latency since the test started
  always_comb begin
    max_lat_d = max_lat_q;
    if (rise_c) begin
      max_lat_d = '0;
    end else if (handshake_c && lat_c > max_lat_q) begin
      max_lat_d = lat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) max_lat_q <= '0;
    else     max_lat_q <= max_lat_d;
  end

  assign max_echo_lat = max_lat_q;
`else
  logic unused_handshake_c;
  assign unused_handshake_c = handshake_c;
`endif

endmodule

// File: tb/tb_bmd_256_echo_scheduler.sv
// Directed testbench for bmd_256_echo_scheduler with a small FIFO model.
module tb_bmd_256_echo_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [63:0] waiting_counter;
  logic [31:0] echo_delay;
  logic [31:0] echo_target;
  logic        fifo_empty;
  logic [63:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic [63:0] ts_data;
  logic        ts_valid;
  logic        tx_ready;
  logic [31:0] echo_count;
  logic        done;
`ifdef BMD_256_ECHO_LAT_STAT_EN
  logic [63:0] max_echo_lat;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // FIFO model: writes from the stimulus process, reads on fifo_rd_en
  logic [63:0] mem [0:63];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int rd_pulses = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses <= rd_pulses + 1;
    end
  end

  always #2 clk = ~clk;

  bmd_256_echo_scheduler #(.TS_W(64), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .trigger         (trigger),
    .waiting_counter (waiting_counter),
    .echo_delay      (echo_delay),
    .echo_target     (echo_target),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .ts_data         (ts_data),
    .ts_valid        (ts_valid),
    .tx_ready        (tx_ready),
    .echo_count      (echo_count),
    .done            (done)
`ifdef BMD_256_ECHO_LAT_STAT_EN
    ,
    .max_echo_lat    (max_echo_lat)
`endif
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [63:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    logic v1, v2, v3;
    rst = 1'b1; trigger = 1'b1; echo_delay = 32'd0; echo_target = 32'd0;
    tx_ready = 1'b0; waiting_counter = 64'h1000;
    push(64'hAA);
    tick(3);
    n_total++;
    if ({fifo_rd_en, ts_valid, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {fifo_rd_en, ts_valid, done});
    else n_pass++;
    n_total++;
    if (ts_data !== 64'h0 || echo_count !== 32'h0) $display("FAIL reset_data ts_data=%h count=%0d want 0/0", ts_data, echo_count);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL reset_first_rd got %b want 1", fifo_rd_en);
    else n_pass++;
    tick(); v1 = ts_valid;
    tick(); v2 = ts_valid;
    tick(); v3 = ts_valid;
    n_total++;
    if ({v1, v2, v3} !== 3'b001) $display("FAIL reset_latency valid_seq got %b want 001", {v1, v2, v3});
    else n_pass++;
    n_total++;
    if (ts_data !== 64'hAA) $display("FAIL reset_ts_data got %h want aa", ts_data);
    else n_pass++;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    n_total++;
    if (echo_count !== 32'd1 || ts_valid !== 1'b0) $display("FAIL reset_handshake count=%0d valid=%b want 1/0", echo_count, ts_valid);
    else n_pass++;
  endtask

  task automatic test_delay;
    logic [63:0] first;
    bit          found;
    found = 1'b0; first = '0;
    waiting_counter = 64'h100; echo_delay = 32'd50;
    push(64'h100);
    tick(3);
    for (int i = 1; i <= 80 && !found; i++) begin
      waiting_counter = 64'h100 + 64'(i);
      tick();
      if (ts_valid === 1'b1) begin found = 1'b1; first = waiting_counter; end
    end
    n_total++;
    if (!found || first !== 64'h132) $display("FAIL delay_release found=%b counter=%h want 132", found, first);
    else n_pass++;
    n_total++;
    if (ts_data !== 64'h100) $display("FAIL delay_ts_data got %h want 100", ts_data);
    else n_pass++;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [63:0] base, first;
    bit          found;
    found = 1'b0; first = '0;
    base = 64'hFFFF_FFFF_FFFF_FFF0;
    waiting_counter = base; echo_delay = 32'h20;
    push(base);
    tick(3);
    for (int i = 1; i <= 80 && !found; i++) begin
      waiting_counter = base + 64'(i);
      tick();
      if (ts_valid === 1'b1) begin found = 1'b1; first = waiting_counter; end
    end
    n_total++;
    if (!found || first !== 64'h10) $display("FAIL wrap_release found=%b counter=%h want 10", found, first);
    else n_pass++;
    n_total++;
    if (ts_data !== base) $display("FAIL wrap_ts_data got %h want %h", ts_data, base);
    else n_pass++;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
  endtask

  task automatic test_target;
    int snap, done_at;
    trigger = 1'b0; tick(2);
    echo_target = 32'd3; echo_delay = 32'd0; waiting_counter = 64'h5000; tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(64'h200 + 64'(k));
    snap = rd_pulses; done_at = 0;
    trigger = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1 && done_at == 0) done_at = i;
    end
    n_total++;
    if (done_at != 13) $display("FAIL target_throughput done_at=%0d want 13", done_at);
    else n_pass++;
    n_total++;
    if (rd_pulses - snap != 3) $display("FAIL target_reads got %0d want 3", rd_pulses - snap);
    else n_pass++;
    n_total++;
    if (echo_count !== 32'd3 || done !== 1'b1) $display("FAIL target_count count=%0d done=%b want 3/1", echo_count, done);
    else n_pass++;
    trigger = 1'b0; tick(2);
    n_total++;
    if (echo_count !== 32'd3) $display("FAIL target_hold_count got %0d want 3", echo_count);
    else n_pass++;
    trigger = 1'b1; tick();
    n_total++;
    if (echo_count !== 32'd0 || done !== 1'b0 || fifo_rd_en !== 1'b1) $display("FAIL target_retrigger count=%0d done=%b rd=%b want 0/0/1", echo_count, done, fifo_rd_en);
    else n_pass++;
    tick(20);
    n_total++;
    if (echo_count !== 32'd2 || done !== 1'b0 || rd_pulses - snap != 5) $display("FAIL target_resume count=%0d done=%b reads=%0d want 2/0/5", echo_count, done, rd_pulses - snap);
    else n_pass++;
    tx_ready = 1'b0; echo_target = 32'd0;
  endtask

  task automatic test_abort;
    int snap;
    logic [31:0] snapc;
    echo_delay = 32'd1000; waiting_counter = 64'h6000;
    push(64'h6000);
    snap = rd_pulses; snapc = echo_count;
    tick(3);
    trigger = 1'b0;
    tick();
    waiting_counter = 64'h7000;
    tick(5);
    n_total++;
    if (ts_valid !== 1'b0 || echo_count !== snapc || rd_pulses - snap != 1) $display("FAIL abort_hold valid=%b count=%0d reads=%0d want 0/%0d/1", ts_valid, echo_count, rd_pulses - snap, snapc);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    trigger = 1'b1; echo_delay = 32'd0; tx_ready = 1'b0;
    push(64'h7000);
    tick(4);
    n_total++;
    if (ts_valid !== 1'b1) $display("FAIL midrst_pre_valid got %b want 1", ts_valid);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++;
    if ({ts_valid, fifo_rd_en} !== 2'b00 || ts_data !== 64'h0 || echo_count !== 32'h0) $display("FAIL midrst_state valid=%b rd=%b data=%h count=%0d want all 0", ts_valid, fifo_rd_en, ts_data, echo_count);
    else n_pass++;
    tick(4);
    n_total++;
    if (ts_valid !== 1'b0) $display("FAIL midrst_entry_lost valid=%b want 0", ts_valid);
    else n_pass++;
  endtask

  task automatic test_back_pressure;
    int snap;
    logic [31:0] snapc;
    bit stable;
    trigger = 1'b1; tx_ready = 1'b0; echo_delay = 32'd0; waiting_counter = 64'h8000;
    push(64'h8001); push(64'h8002);
    snapc = echo_count;
    tick(4);
    trigger = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(ts_valid === 1'b1 && ts_data === 64'h8001)) stable = 1'b0;
    end
    n_total++;
    if (!stable) $display("FAIL stall_stable last valid=%b data=%h want 1/8001", ts_valid, ts_data);
    else n_pass++;
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    n_total++;
    if (echo_count !== snapc + 32'd1 || ts_valid !== 1'b0) $display("FAIL stall_handshake count=%0d valid=%b want %0d/0", echo_count, ts_valid, snapc + 32'd1);
    else n_pass++;
    snap = rd_pulses;
    tick(5);
    n_total++;
    if (rd_pulses != snap || ts_valid !== 1'b0) $display("FAIL stall_no_reads reads=%0d valid=%b want 0/0", rd_pulses - snap, ts_valid);
    else n_pass++;
  endtask

`ifdef BMD_256_ECHO_LAT_STAT_EN
  task automatic test_lat_stat;
    trigger = 1'b1; tx_ready = 1'b1; tick(8);
    trigger = 1'b0; tx_ready = 1'b0; tick(2);
    waiting_counter = 64'h0; echo_delay = 32'd0;
    push(64'h0); push(64'h10);
    trigger = 1'b1;
    tick(4);
    n_total++;
    if (max_echo_lat !== 64'h0 || ts_data !== 64'h0) $display("FAIL lat_cleared max=%h data=%h want 0/0", max_echo_lat, ts_data);
    else n_pass++;
    waiting_counter = 64'h40; tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    tick(3);
    waiting_counter = 64'h30; tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    n_total++;
    if (max_echo_lat !== 64'h40) $display("FAIL lat_max got %h want 40", max_echo_lat);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_delay();
    test_wrap();
    test_target();
    test_abort();
    test_mid_reset();
    test_back_pressure();
`ifdef BMD_256_ECHO_LAT_STAT_EN
    test_lat_stat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
